// File: rtl/div_result_bcd_if.sv
// div_result_bcd_if: bus between the shift-subtract divider and the BCD
// result stage.
//   done/error/quotient/remainder : divider -> converter (one-cycle result)
//   q_bcd/r_bcd/err_flag/valid/busy : converter -> display driver
// master = divider/display side, slave = div_result_bcd.
interface div_result_bcd_if #(
  parameter int SIZE   = 8,
  parameter int DIGITS = 3
);
  logic                  done;
  logic                  error;
  logic [SIZE-1:0]       quotient;
  logic [SIZE-1:0]       remainder;
  logic [4*DIGITS-1:0]   q_bcd;
  logic [4*DIGITS-1:0]   r_bcd;
  logic                  err_flag;
  logic                  valid;
  logic                  busy;

  modport master (
    output done, error, quotient, remainder,
    input  q_bcd, r_bcd, err_flag, valid, busy
  );

  modport slave (
    input  done, error, quotient, remainder,
    output q_bcd, r_bcd, err_flag, valid, busy
  );
endinterface

// File: rtl/div_result_bcd.sv
// div_result_bcd: converts the divider's quotient and remainder to packed BCD
// with an iterative double-dabble engine (one shift per clock, both values in
// parallel) and holds the result for the seven-segment driver.
//
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high; abandons any conversion
//   overrun  (only with OVERRUN_DETECT_EN) sticky: done arrived mid-conversion
//   bus      div_result_bcd_if.slave
//              in : done, error, quotient, remainder
//              out: q_bcd, r_bcd (digit 0 in [3:0]), err_flag, valid, busy
//
// Optional build macro: OVERRUN_DETECT_EN adds the `overrun` output.
//
// A good result is presented SIZE edges after the capture edge; a
// divide-by-zero result (error=1) is shown as all-4'hF digits at the capture
// edge with no conversion.

// One double-dabble lane: binary shift register plus BCD accumulator.
// bcd_nxt is the accumulator value after the current iteration, so the top
// level can register the final digits on the same edge as the last shift.
module div_result_bcd_lane #(
  parameter int SIZE   = 8,
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load,
  input  logic                step,
  input  logic [SIZE-1:0]     din,
  output logic [4*DIGITS-1:0] bcd_nxt
);
  localparam int BW = 4 * DIGITS;

  logic [SIZE-1:0] bin;
  logic [BW-1:0]   bcd;
  logic [BW-1:0]   adj;

  // Add-3 correction on every digit >= 5, done before the shift so the
  // doubled digit carries into the next one correctly.
  always_comb begin
    adj = bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5)
        adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // {bcd,bin} << 1: the top adjusted bit falls off, which cannot carry data
  // because 10^DIGITS exceeds the largest SIZE-bit value.
  assign bcd_nxt = BW'({adj, bin[SIZE-1]});

  always_ff @(posedge clk) begin
    if (reset) begin
      bin <= '0;
      bcd <= '0;
    end else if (load) begin
      bin <= din;
      bcd <= '0;
    end else if (step) begin
      bin <= bin << 1;
      bcd <= bcd_nxt;
    end
  end
endmodule

module div_result_bcd #(
  parameter int SIZE   = 8,
  parameter int DIGITS = 3
) (
  input  logic            clk,
  input  logic            reset,
`ifdef OVERRUN_DETECT_EN
  output logic            overrun,
`endif
  div_result_bcd_if.slave bus
);
  localparam int BW    = 4 * DIGITS;
  localparam int CW    = $clog2(SIZE + 1);
  localparam int LANES = 2;  // lane 0 = quotient, lane 1 = remainder

  typedef enum logic [1:0] {IDLE, SHIFT, RESULT} state_t;

  state_t                       state, state_nxt;
  logic [CW-1:0]                cnt;
  logic                         load, step, fin, err_cap;
  logic [LANES-1:0][SIZE-1:0]   din;
  logic [LANES-1:0][BW-1:0]     bcd_nxt;

  logic [BW-1:0]                q_bcd_r, r_bcd_r;
  logic                         err_flag_r, valid_r, busy_r;

  assign din = {bus.remainder, bus.quotient};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    div_result_bcd_lane #(.SIZE(SIZE), .DIGITS(DIGITS)) u_lane (
      .clk     (clk),
      .reset   (reset),
      .load    (load),
      .step    (step),
      .din     (din[i]),
      .bcd_nxt (bcd_nxt[i])
    );
  end

  // Next state and per-edge controls. done is only looked at outside SHIFT,
  // so a result arriving mid-conversion is dropped.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    fin       = 1'b0;
    err_cap   = 1'b0;
    case (state)
      IDLE, RESULT: begin
        if (bus.done) begin
          if (bus.error) begin
            err_cap   = 1'b1;
            state_nxt = RESULT;
          end else begin
            load      = 1'b1;
            state_nxt = SHIFT;
          end
        end
      end
      SHIFT: begin
        step = 1'b1;
        if (cnt == CW'(1)) begin
          fin       = 1'b1;
          state_nxt = RESULT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= CW'(SIZE);
    else if (step) cnt <= cnt - CW'(1);
  end

  // Result registers only change on entry to RESULT; starting a conversion
  // drops valid but leaves the previous digits on the display.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_bcd_r    <= '0;
      r_bcd_r    <= '0;
      err_flag_r <= 1'b0;
      valid_r    <= 1'b0;
      busy_r     <= 1'b0;
    end else if (err_cap) begin
      q_bcd_r    <= {DIGITS{4'hF}};
      r_bcd_r    <= {DIGITS{4'hF}};
      err_flag_r <= 1'b1;
      valid_r    <= 1'b1;
      busy_r     <= 1'b0;
    end else if (load) begin
      valid_r    <= 1'b0;
      busy_r     <= 1'b1;
    end else if (fin) begin
      q_bcd_r    <= bcd_nxt[0];
      r_bcd_r    <= bcd_nxt[1];
      err_flag_r <= 1'b0;
      valid_r    <= 1'b1;
      busy_r     <= 1'b0;
    end
  end

`ifdef OVERRUN_DETECT_EN
  always_ff @(posedge clk) begin
    if (reset)                          overrun <= 1'b0;
    else if (state == SHIFT && bus.done) overrun <= 1'b1;
  end
`endif

  assign bus.q_bcd    = q_bcd_r;
  assign bus.r_bcd    = r_bcd_r;
  assign bus.err_flag = err_flag_r;
  assign bus.valid    = valid_r;
  assign bus.busy     = busy_r;
endmodule

// File: tb/tb_div_result_bcd.sv
// Bench for div_result_bcd: SIZE=8/DIGITS=3 and SIZE=2/DIGITS=1 instances.
// The driver predicts each result (value, error flag, edge it must appear on)
// into a per-instance queue; a negedge monitor pops it when the DUT presents
// a new result and otherwise checks that the outputs hold.
module tb_div_result_bcd;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst8 = 1'b1;
  logic rst2 = 1'b1;

  div_result_bcd_if #(.SIZE(8), .DIGITS(3)) bus8 ();
  div_result_bcd_if #(.SIZE(2), .DIGITS(1)) bus2 ();

`ifdef OVERRUN_DETECT_EN
  logic ovr8, ovr2;
  logic ovr_model8 = 1'b0;
`endif

  div_result_bcd #(.SIZE(8), .DIGITS(3)) dut8 (
    .clk   (clk),
    .reset (rst8),
`ifdef OVERRUN_DETECT_EN
    .overrun (ovr8),
`endif
    .bus   (bus8)
  );

  div_result_bcd #(.SIZE(2), .DIGITS(1)) dut2 (
    .clk   (clk),
    .reset (rst2),
`ifdef OVERRUN_DETECT_EN
    .overrun (ovr2),
`endif
    .bus   (bus2)
  );

  typedef struct {
    int          edge_n;
    logic [11:0] q;
    logic [11:0] r;
    logic        err;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  int cyc    = 0;   // number of rising edges so far
  int n_cmp  = 0;
  int n_bad  = 0;
  int last_ok[2] = '{-100, -100};  // capture edge of latest good conversion

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, cyc);
    end
  endtask

  // Decimal digits of v, digit 0 in the low nibble.
  function automatic logic [11:0] bcd_of(input int v);
    logic [11:0] b;
    int t;
    t = v;
    for (int d = 0; d < 3; d++) begin
      b[4*d +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return b;
  endfunction

  // ---------------- driver helpers (called at posedge + #1) ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int id, input logic e, input logic [7:0] q, input logic [7:0] r);
    exp_t x;
    int j, sz, qv, rv;
    j  = cyc + 1;
    sz = (id == 0) ? 8 : 2;
    qv = (id == 0) ? int'(q) : int'(q[1:0]);
    rv = (id == 0) ? int'(r) : int'(r[1:0]);
    if (id == 0) begin
      bus8.done = 1'b1; bus8.error = e; bus8.quotient = q; bus8.remainder = r;
    end else begin
      bus2.done = 1'b1; bus2.error = e; bus2.quotient = q[1:0]; bus2.remainder = r[1:0];
    end
    if (j > last_ok[id] + sz) begin
      x.edge_n = e ? j : j + sz;
      x.q      = e ? ((id == 0) ? 12'hFFF : 12'h00F) : bcd_of(qv);
      x.r      = e ? ((id == 0) ? 12'hFFF : 12'h00F) : bcd_of(rv);
      x.err    = e;
      if (id == 0) sb0.push_back(x); else sb1.push_back(x);
      if (!e) last_ok[id] = j;
    end
`ifdef OVERRUN_DETECT_EN
    else if (id == 0) ovr_model8 = 1'b1;
`endif
    @(posedge clk);
    #1;
    // error/operands while done=0 must be ignored, so scramble them
    if (id == 0) begin
      bus8.done = 1'b0; bus8.error = 1'($urandom);
      bus8.quotient = 8'($urandom); bus8.remainder = 8'($urandom);
    end else begin
      bus2.done = 1'b0; bus2.error = 1'($urandom);
      bus2.quotient = 2'($urandom); bus2.remainder = 2'($urandom);
    end
  endtask

  task automatic rst_pulse(input int id);
    int j;
    j = cyc + 1;
    if (id == 0) begin
      rst8 = 1'b1;
      while (sb0.size() > 0 && sb0[$].edge_n >= j) void'(sb0.pop_back());
`ifdef OVERRUN_DETECT_EN
      ovr_model8 = 1'b0;
`endif
    end else begin
      rst2 = 1'b1;
      while (sb1.size() > 0 && sb1[$].edge_n >= j) void'(sb1.pop_back());
    end
    last_ok[id] = -100;
    @(posedge clk);
    #1;
    if (id == 0) rst8 = 1'b0; else rst2 = 1'b0;
  endtask

  // ---------------- monitor ----------------
  logic        vprev[2] = '{1'b0, 1'b0};
  logic        dpend[2] = '{1'b0, 1'b0};
  logic        epend[2] = '{1'b0, 1'b0};
  logic        rpend[2] = '{1'b1, 1'b1};
  logic [11:0] lq[2]    = '{12'h0, 12'h0};
  logic [11:0] lr[2]    = '{12'h0, 12'h0};
  logic        le[2]    = '{1'b0, 1'b0};

  task automatic mon(input int id, input logic v, input logic [11:0] q, input logic [11:0] r,
                     input logic e, input logic b, input logic d, input logic er, input logic rs);
    exp_t  x;
    string t;
    t = (id == 0) ? "s8" : "s2";
    if (rpend[id]) begin
      chk({t, " reset q_bcd"}, 32'(q), 0);
      chk({t, " reset r_bcd"}, 32'(r), 0);
      chk({t, " reset err_flag"}, 32'(e), 0);
      chk({t, " reset valid"}, 32'(v), 0);
      chk({t, " reset busy"}, 32'(b), 0);
      lq[id] = 12'h0; lr[id] = 12'h0; le[id] = 1'b0;
    end else if (v && (!vprev[id] || (dpend[id] && epend[id]))) begin
      if ((id == 0 && sb0.size() == 0) || (id == 1 && sb1.size() == 0)) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s unexpected result: q=%0h r=%0h err=%0b expected none", t, q, r, e);
      end else begin
        x = (id == 0) ? sb0.pop_front() : sb1.pop_front();
        chk({t, " result edge"}, 32'(cyc), 32'(x.edge_n));
        chk({t, " q_bcd"}, 32'(q), 32'(x.q));
        chk({t, " r_bcd"}, 32'(r), 32'(x.r));
        chk({t, " err_flag"}, 32'(e), 32'(x.err));
        chk({t, " busy at result"}, 32'(b), 0);
      end
      lq[id] = q; lr[id] = r; le[id] = e;
    end else begin
      chk({t, " hold q_bcd"}, 32'(q), 32'(lq[id]));
      chk({t, " hold r_bcd"}, 32'(r), 32'(lr[id]));
      chk({t, " hold err_flag"}, 32'(e), 32'(le[id]));
    end
    vprev[id] = v;
    dpend[id] = d;
    epend[id] = er;
    rpend[id] = rs;
  endtask

  always @(negedge clk) begin
    mon(0, bus8.valid, bus8.q_bcd, bus8.r_bcd, bus8.err_flag, bus8.busy,
        bus8.done, bus8.error, rst8);
    mon(1, bus2.valid, 12'(bus2.q_bcd), 12'(bus2.r_bcd), bus2.err_flag, bus2.busy,
        bus2.done, bus2.error, rst2);
  end

  // ---------------- stimulus ----------------
  initial begin
    bus8.done = 1'b0; bus8.error = 1'b0; bus8.quotient = '0; bus8.remainder = '0;
    bus2.done = 1'b0; bus2.error = 1'b0; bus2.quotient = '0; bus2.remainder = '0;
    idle(2);
    rst8 = 1'b0;
    rst2 = 1'b0;
`ifdef OVERRUN_DETECT_EN
    chk("overrun after reset", 32'(ovr8), 0);
`endif

    // 200 / 7: busy the edge after capture, result 8 edges later
    pulse(0, 1'b0, 8'd200, 8'd7);
    chk("busy after capture", 32'(bus8.busy), 1);
    chk("valid low in conversion", 32'(bus8.valid), 0);
    idle(8);
    chk("valid after 8 edges", 32'(bus8.valid), 1);
    chk("busy clear after result", 32'(bus8.busy), 0);

    // 255/0, then 0/99 the cycle after valid rises
    pulse(0, 1'b0, 8'd255, 8'd0);
    idle(8);
    pulse(0, 1'b0, 8'd0, 8'd99);
    idle(8);

    // divide-by-zero: blank code at the capture edge, then a clean result
    pulse(0, 1'b1, 8'hxx, 8'hxx);
    chk("err valid same edge", 32'(bus8.valid), 1);
    chk("err flag same edge", 32'(bus8.err_flag), 1);
    pulse(0, 1'b0, 8'd10, 8'd3);
    idle(8);

    // done at iteration 4 is dropped
    pulse(0, 1'b0, 8'd123, 8'd0);
    idle(3);
    pulse(0, 1'b0, 8'd45, 8'd45);
    idle(5);
`ifdef OVERRUN_DETECT_EN
    chk("overrun set", 32'(ovr8), 1);
    idle(3);
    chk("overrun sticky", 32'(ovr8), 1);
`endif

    // reset at iteration 5, then 64/1
    pulse(0, 1'b0, 8'd77, 8'd88);
    idle(4);
    rst_pulse(0);
    chk("mid reset valid", 32'(bus8.valid), 0);
    chk("mid reset q_bcd", 32'(bus8.q_bcd), 0);
`ifdef OVERRUN_DETECT_EN
    chk("overrun cleared by reset", 32'(ovr8), 0);
`endif
    pulse(0, 1'b0, 8'd64, 8'd1);
    idle(8);

    // random traffic, including drops during conversion and occasional reset
    for (int n = 0; n < 80; n++) begin
      pulse(0, ($urandom_range(0, 5) == 0), 8'($urandom), 8'($urandom));
      idle($urandom_range(0, 10));
      if ($urandom_range(0, 15) == 0) rst_pulse(0);
    end
    idle(10);

    // SIZE=2 full sweep plus an error result
    for (int q = 0; q < 4; q++) begin
      for (int r = 0; r < 4; r++) begin
        pulse(1, 1'b0, 8'(q), 8'(r));
        idle(2);
      end
    end
    pulse(1, 1'b1, 8'd0, 8'd0);
    pulse(1, 1'b0, 8'd3, 8'd2);
    idle(10);

    chk("s8 scoreboard drained", 32'(sb0.size()), 0);
    chk("s2 scoreboard drained", 32'(sb1.size()), 0);
`ifdef OVERRUN_DETECT_EN
    chk("overrun final", 32'(ovr8), 32'(ovr_model8));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
